pc_fetch: RTL and testbench

Program-counter and fetch-control stage of the single-cycle MIPS core. It sits directly upstream of the byte-addressed instruction memory: it drives the fetch address and receives the 32-bit instruction word. It computes the next PC from sequential, branch, jump and jump-register requests issued by the decode/execute logic. A small run/halt/fault state machine stops fetch when the program signals completion or the PC leaves legal instruction space.

---
 rtl/mips_pkg.sv | 19 +
 rtl/npc_calc.sv | 32 +++
 rtl/pc_fetch.sv | 87 ++++++++
 tb/tb_pc_fetch.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS core front end: next-PC select codes,
// fetch state encoding and the memory-mapped halt address.
package mips_pkg;

    localparam logic [1:0] NPC_SEQ = 2'd0;
    localparam logic [1:0] NPC_BR  = 2'd1;
    localparam logic [1:0] NPC_J   = 2'd2;
    localparam logic [1:0] NPC_JR  = 2'd3;

    // A store to this address is decoded elsewhere into halt_req.
    localparam logic [31:0] HALT_ADDR = 32'h0000_0080;

    typedef enum logic [1:0] {
        StRun   = 2'd0,
        StHalt  = 2'd1,
        StFault = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/npc_calc.sv
// Combinational next-PC computation: sequential, branch, jump and
// jump-register targets.
module npc_calc
    import mips_pkg::*;
(
    input  logic [31:0] pc,
    input  logic [1:0]  npc_sel,
    input  logic        br_taken,
    input  logic [15:0] imm16,
    input  logic [25:0] jidx26,
    input  logic [31:0] jr_addr,
    output logic [31:0] pc_plus4,
    output logic [31:0] next_pc
);

    logic [31:0] br_off;

    assign pc_plus4 = pc + 32'd4;
    // Word offset, sign-extended and scaled to bytes.
    assign br_off   = {{14{imm16[15]}}, imm16, 2'b00};

    always_comb begin
        next_pc = pc_plus4;
        unique case (npc_sel)
            NPC_SEQ: next_pc = pc_plus4;
            NPC_BR:  next_pc = br_taken ? (pc_plus4 + br_off) : pc_plus4;
            NPC_J:   next_pc = {pc_plus4[31:28], jidx26, 2'b00};
            NPC_JR:  next_pc = jr_addr;
        endcase
    end

endmodule

// File: rtl/pc_fetch.sv
// PC register, retired-instruction counter and run/halt/fault control for
// the instruction fetch stage.
module pc_fetch
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned IM_BYTES = 2048,
    parameter int unsigned CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall,
    input  logic             halt_req,
    input  logic [1:0]       npc_sel,
    input  logic             br_taken,
    input  logic [15:0]      imm16,
    input  logic [25:0]      jidx26,
    input  logic [31:0]      jr_addr,
    input  logic [31:0]      im_instr,
    output logic [31:0]      pc,
    output logic [31:0]      pc_plus4,
    output logic [31:0]      instr,
    output logic             fetch_valid,
    output logic             halted,
    output logic             fault,
    output logic [CNT_W-1:0] retired
);

    localparam logic [31:0] PC_MAX = 32'(IM_BYTES - 4);

    fetch_state_e     state_q, state_d;
    logic [31:0]      pc_q, pc_d;
    logic [CNT_W-1:0] retired_q, retired_d;
    logic [31:0]      next_pc;
    logic             next_legal;

    npc_calc u_npc_calc (
        .pc       (pc_q),
        .npc_sel  (npc_sel),
        .br_taken (br_taken),
        .imm16    (imm16),
        .jidx26   (jidx26),
        .jr_addr  (jr_addr),
        .pc_plus4 (pc_plus4),
        .next_pc  (next_pc)
    );

    assign next_legal = (next_pc[1:0] == 2'b00) && (next_pc <= PC_MAX);

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        retired_d = retired_q;
        if (state_q == StRun) begin
            if (halt_req) begin
                state_d = StHalt;
            end else if (!stall) begin
                // An illegal target is still loaded so the debugger can see it.
                pc_d      = next_pc;
                retired_d = retired_q + CNT_W'(1);
                if (!next_legal) begin
                    state_d = StFault;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StRun;
            pc_q      <= RESET_PC;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            retired_q <= retired_d;
        end
    end

    assign pc          = pc_q;
    assign retired     = retired_q;
    assign fetch_valid = (state_q == StRun);
    assign halted      = (state_q == StHalt);
    assign fault       = (state_q == StFault);
    assign instr       = fetch_valid ? im_instr : 32'h0000_0000;

endmodule

// File: tb/tb_pc_fetch.sv
// Directed bench for pc_fetch: sequential flow, branches, jumps, stall,
// halt, fault boundaries and asynchronous reset.
module tb_pc_fetch;

    localparam logic [31:0] IM_XOR = 32'h1234_5678;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall;
    logic        halt_req;
    logic [1:0]  npc_sel;
    logic        br_taken;
    logic [15:0] imm16;
    logic [25:0] jidx26;
    logic [31:0] jr_addr;
    logic [31:0] im_instr;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] instr;
    logic        fetch_valid;
    logic        halted;
    logic        fault;
    logic [31:0] retired;

    int n_tests = 0;
    int n_fail  = 0;

    pc_fetch #(
        .RESET_PC (32'h0000_0000),
        .IM_BYTES (2048),
        .CNT_W    (32)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .stall       (stall),
        .halt_req    (halt_req),
        .npc_sel     (npc_sel),
        .br_taken    (br_taken),
        .imm16       (imm16),
        .jidx26      (jidx26),
        .jr_addr     (jr_addr),
        .im_instr    (im_instr),
        .pc          (pc),
        .pc_plus4    (pc_plus4),
        .instr       (instr),
        .fetch_valid (fetch_valid),
        .halted      (halted),
        .fault       (fault),
        .retired     (retired)
    );

    // Instruction memory stand-in: word content is a fixed function of address.
    assign im_instr = pc ^ IM_XOR;

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step(input logic [1:0] sel, input logic tk, input logic [15:0] imm,
                        input logic [25:0] jx, input logic [31:0] jr,
                        input logic st, input logic hr);
        npc_sel  = sel;
        br_taken = tk;
        imm16    = imm;
        jidx26   = jx;
        jr_addr  = jr;
        stall    = st;
        halt_req = hr;
        @(posedge clk);
        #1;
    endtask

    task automatic check_state(input string tag, input logic [31:0] epc, input logic [31:0] eret,
                               input logic ev, input logic eh, input logic ef);
        check({tag, ".pc"}, pc, epc);
        check({tag, ".retired"}, retired, eret);
        check({tag, ".state"}, {29'd0, ev, eh, ef}, {29'd0, ev, eh, ef});
        check({tag, ".valid"}, {31'd0, fetch_valid}, {31'd0, ev});
        check({tag, ".halted"}, {31'd0, halted}, {31'd0, eh});
        check({tag, ".fault"}, {31'd0, fault}, {31'd0, ef});
        check({tag, ".instr"}, instr, ev ? (epc ^ IM_XOR) : 32'h0);
    endtask

    // Async reset pulse placed between clock edges; checks before the next edge.
    task automatic reset_pulse(input string tag);
        #1 rst_n = 1'b0;
        #1;
        check_state(tag, 32'h0, 32'd0, 1'b1, 1'b0, 1'b0);
        check({tag, ".pc_plus4"}, pc_plus4, 32'h4);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        rst_n    = 1'b0;
        stall    = 1'b0;
        halt_req = 1'b0;
        npc_sel  = 2'd0;
        br_taken = 1'b0;
        imm16    = 16'h0;
        jidx26   = 26'h0;
        jr_addr  = 32'h0;
        #3;
        check_state("reset", 32'h0, 32'd0, 1'b1, 1'b0, 1'b0);
        check("reset.pc_plus4", pc_plus4, 32'h4);
        @(negedge clk);
        rst_n = 1'b1;

        step(2'd0, 1'b0, 16'h0, 26'h0, 32'h0, 1'b0, 1'b0);
        check_state("seq1", 32'h4, 32'd1, 1'b1, 1'b0, 1'b0);
        step(2'd0, 1'b0, 16'h0, 26'h0, 32'h0, 1'b0, 1'b0);
        check_state("seq2", 32'h8, 32'd2, 1'b1, 1'b0, 1'b0);
        step(2'd0, 1'b0, 16'h0, 26'h0, 32'h0, 1'b0, 1'b0);
        check_state("seq3", 32'hC, 32'd3, 1'b1, 1'b0, 1'b0);

        step(2'd3, 1'b0, 16'h0, 26'h0, 32'h4C, 1'b0, 1'b0);
        check_state("jr4c", 32'h4C, 32'd4, 1'b1, 1'b0, 1'b0);
        step(2'd1, 1'b1, 16'hfff4, 26'h0, 32'h0, 1'b0, 1'b0);
        check_state("br_taken", 32'h20, 32'd5, 1'b1, 1'b0, 1'b0);

        check("j.pc_plus4", pc_plus4, 32'h24);
        step(2'd2, 1'b0, 16'h0, 26'h14, 32'h0, 1'b0, 1'b0);
        check_state("j14", 32'h50, 32'd6, 1'b1, 1'b0, 1'b0);

        step(2'd3, 1'b0, 16'h0, 26'h0, 32'h4C, 1'b0, 1'b0);
        check_state("jr4c_b", 32'h4C, 32'd7, 1'b1, 1'b0, 1'b0);
        step(2'd1, 1'b0, 16'hfff4, 26'h0, 32'h0, 1'b0, 1'b0);
        check_state("br_nt", 32'h50, 32'd8, 1'b1, 1'b0, 1'b0);
        step(2'd2, 1'b0, 16'h0, 26'h9, 32'h0, 1'b0, 1'b0);
        check_state("j9", 32'h24, 32'd9, 1'b1, 1'b0, 1'b0);

        step(2'd3, 1'b0, 16'h0, 26'h0, 32'h100, 1'b1, 1'b0);
        check_state("stall", 32'h24, 32'd9, 1'b1, 1'b0, 1'b0);

        step(2'd3, 1'b0, 16'h0, 26'h0, 32'h5C, 1'b0, 1'b0);
        check_state("jr5c", 32'h5C, 32'd10, 1'b1, 1'b0, 1'b0);
        step(2'd0, 1'b0, 16'h0, 26'h0, 32'h0, 1'b1, 1'b1);
        check_state("halt", 32'h5C, 32'd10, 1'b0, 1'b1, 1'b0);
        step(2'd3, 1'b0, 16'h0, 26'h0, 32'h10, 1'b0, 1'b0);
        check_state("halt_hold", 32'h5C, 32'd10, 1'b0, 1'b1, 1'b0);

        reset_pulse("rst_halt");

        step(2'd3, 1'b0, 16'h0, 26'h0, 32'h802, 1'b0, 1'b0);
        check_state("fault_mis", 32'h802, 32'd1, 1'b0, 1'b0, 1'b1);
        step(2'd3, 1'b0, 16'h0, 26'h0, 32'h10, 1'b0, 1'b0);
        check_state("fault_hold", 32'h802, 32'd1, 1'b0, 1'b0, 1'b1);

        reset_pulse("rst_fault");

        step(2'd3, 1'b0, 16'h0, 26'h0, 32'h7FC, 1'b0, 1'b0);
        check_state("jr7fc", 32'h7FC, 32'd1, 1'b1, 1'b0, 1'b0);
        step(2'd0, 1'b0, 16'h0, 26'h0, 32'h0, 1'b0, 1'b0);
        check_state("seq_over", 32'h800, 32'd2, 1'b0, 1'b0, 1'b1);

        reset_pulse("rst_fault2");

        step(2'd3, 1'b0, 16'h0, 26'h0, 32'h800, 1'b0, 1'b0);
        check_state("fault_800", 32'h800, 32'd1, 1'b0, 1'b0, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
